// File: rtl/prog_clock_divider.sv
// prog_clock_divider: NCH independent programmable clock dividers sharing one source clock.
//
// Each channel counts 0..R-1 on clk_ext and drives a registered divided clock that is high for
// the first half of the count. New ratios are captured into per-channel shadow registers by
// cfg_load. Each enabled channel applies its shadow ratio at its own next wrap, so a switch
// never produces a runt pulse. A disabled channel (R < 2) applies it on the next edge. align
// restarts every enabled channel in phase.
//
// Optional feature (macro ODD_DUTY50_EN): odd ratios get 50% duty. A falling-edge retimed
// copy of the high-phase term is ANDed with it. Without the macro, odd ratios are high for
// (R-1)/2 cycles and the design contains no falling-edge logic.
//
// Ports:
//   clk_ext    in   source clock
//   rst_n      in   asynchronous active-low reset
//   div_ratio  in   packed ratios, channel k uses bits [k*CW +: CW]
//   cfg_load   in   one-cycle strobe capturing div_ratio into the shadow ratios
//   align      in   one-cycle strobe restarting all enabled channels in phase
//   clk_div    out  divided clocks, one per channel
//   tc         out  one-cycle pulse per channel on each counter wrap
//   cfg_busy   out  high while any captured ratio is still pending
//   cfg_err    out  one-cycle pulse when a cfg_load arrives while busy
module prog_clock_divider #(
  parameter int unsigned NCH       = 2,
  parameter int unsigned CW        = 4,
  parameter int unsigned DEF_RATIO = 2
) (
  input  logic              clk_ext,
  input  logic              rst_n,
  input  logic [NCH*CW-1:0] div_ratio,
  input  logic              cfg_load,
  input  logic              align,
  output logic [NCH-1:0]    clk_div,
  output logic [NCH-1:0]    tc,
  output logic              cfg_busy,
  output logic              cfg_err
);

  localparam logic [CW-1:0] RatioRst = CW'(DEF_RATIO);
  // Reset the counter to its last value so the first edge after reset wraps every channel.
  // A default ratio below 2 leaves the channel disabled, where the counter must sit at 0.
  localparam logic [CW-1:0] CntRst   = (DEF_RATIO >= 2) ? CW'(DEF_RATIO - 1) : '0;

  logic [CW-1:0]  r_q   [NCH];
  logic [CW-1:0]  r_d   [NCH];
  logic [CW-1:0]  s_q   [NCH];
  logic [CW-1:0]  s_d   [NCH];
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] p_q, p_d;
  logic [NCH-1:0] rise_q, rise_d;
  logic [NCH-1:0] tc_q, tc_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic           load_ok;

  always_comb begin
    logic          en;
    logic          restart;
    logic          en_next;
    logic [CW-1:0] field;
    logic [CW-1:0] half;

    en      = 1'b0;
    restart = 1'b0;
    en_next = 1'b0;
    field   = '0;
    half    = '0;
    load_ok = cfg_load && !busy_q;
    err_d   = cfg_load && busy_q;

    for (int k = 0; k < NCH; k++) begin
      r_d[k]   = r_q[k];
      s_d[k]   = s_q[k];
      p_d[k]   = p_q[k];
      cnt_d[k] = cnt_q[k];

      field   = div_ratio[k*CW +: CW];
      en      = r_q[k] > CW'(1);
      // A natural wrap coinciding with align collapses into one restart.
      restart = en && (align || (cnt_q[k] == r_q[k] - CW'(1)));

      if (load_ok && align) begin
        // Align together with an accepted load applies the new ratio at once.
        r_d[k]   = field;
        s_d[k]   = field;
        p_d[k]   = 1'b0;
        cnt_d[k] = '0;
      end else if (p_q[k] && (restart || !en)) begin
        r_d[k]   = s_q[k];
        p_d[k]   = 1'b0;
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = (restart || !en) ? '0 : cnt_q[k] + CW'(1);
        // An accepted load implies no channel is pending, so it never races an apply.
        if (load_ok) begin
          s_d[k] = field;
          p_d[k] = 1'b1;
        end
      end

      // Outputs are computed from next state so they register together with the counter.
      en_next  = r_d[k] > CW'(1);
      half     = r_d[k] >> 1;
      tc_d[k]  = en_next && (cnt_d[k] == '0);
`ifdef ODD_DUTY50_EN
      // Odd ratios keep one extra high cycle here; the falling-edge AND trims it by half.
      rise_d[k] = en_next && (r_d[k][0] ? (cnt_d[k] <= half) : (cnt_d[k] < half));
`else
      rise_d[k] = en_next && (cnt_d[k] < half);
`endif
    end

    busy_d = |p_d;
  end

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        r_q[k]   <= RatioRst;
        s_q[k]   <= RatioRst;
        cnt_q[k] <= CntRst;
      end
      p_q    <= '0;
      rise_q <= '0;
      tc_q   <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        r_q[k]   <= r_d[k];
        s_q[k]   <= s_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      p_q    <= p_d;
      rise_q <= rise_d;
      tc_q   <= tc_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

`ifdef ODD_DUTY50_EN
  logic [NCH-1:0] rise_neg_q;

  // Half-cycle delayed copy of the high-phase term.
  always_ff @(negedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      rise_neg_q <= '0;
    end else begin
      rise_neg_q <= rise_q;
    end
  end

  always_comb begin
    clk_div = '0;
    for (int k = 0; k < NCH; k++) begin
      clk_div[k] = r_q[k][0] ? (rise_q[k] & rise_neg_q[k]) : rise_q[k];
    end
  end
`else
  assign clk_div = rise_q;
`endif

  assign tc       = tc_q;
  assign cfg_busy = busy_q;
  assign cfg_err  = err_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider (NCH=2, CW=4, DEF_RATIO=2).
// Outputs are sampled 1 time unit after the rising edge unless noted.
module tb_prog_clock_divider;

  logic       clk_ext;
  logic       rst_n;
  logic [7:0] div_ratio;
  logic       cfg_load;
  logic       align;
  logic [1:0] clk_div;
  logic [1:0] tc;
  logic       cfg_busy;
  logic       cfg_err;

  int errors;
  int checks;

  prog_clock_divider #(
    .NCH      (2),
    .CW       (4),
    .DEF_RATIO(2)
  ) dut (
    .clk_ext  (clk_ext),
    .rst_n    (rst_n),
    .div_ratio(div_ratio),
    .cfg_load (cfg_load),
    .align    (align),
    .clk_div  (clk_div),
    .tc       (tc),
    .cfg_busy (cfg_busy),
    .cfg_err  (cfg_err)
  );

  initial clk_ext = 1'b0;
  always #5 clk_ext = ~clk_ext;

  // Expected clk_div just after a rising edge, for a channel at count cnt of ratio r whose
  // previous cycle was in the low phase.
  function automatic logic exp_hi(input int cnt, input int r);
    if (r < 2) return 1'b0;
`ifdef ODD_DUTY50_EN
    if (r % 2 == 1) return (cnt >= 1) && (cnt <= r / 2);
`endif
    return cnt < r / 2;
  endfunction

  task automatic step();
    @(posedge clk_ext);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] e;
    rst_n     = 1'b0;
    cfg_load  = 1'b0;
    align     = 1'b0;
    div_ratio = '0;
    repeat (3) @(posedge clk_ext);
    #1;
    checks++;
    if (clk_div !== 2'b00) begin errors++; $display("FAIL reset_clk_div: got %b want 00", clk_div); end
    checks++;
    if (tc !== 2'b00) begin errors++; $display("FAIL reset_tc: got %b want 00", tc); end
    checks++;
    if (cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", cfg_busy); end
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", cfg_err); end
    rst_n = 1'b1;
    // Default ratio 2: first edge wraps, then toggles every cycle.
    for (int i = 0; i <= 6; i++) begin
      step();
      e = (i % 2 == 0) ? 2'b11 : 2'b00;
      checks++;
      if (clk_div !== e) begin errors++; $display("FAIL default_clk_div[%0d]: got %b want %b", i, clk_div, e); end
      checks++;
      if (tc !== e) begin errors++; $display("FAIL default_tc[%0d]: got %b want %b", i, tc, e); end
    end
  endtask

  task automatic test_load();
    logic [1:0] e_clk;
    logic [1:0] e_tc;
    div_ratio = {4'd6, 4'd4};
    cfg_load  = 1'b1;
    step();
    cfg_load = 1'b0;
    checks++;
    if (clk_div !== 2'b00) begin errors++; $display("FAIL load_midperiod_clk: got %b want 00", clk_div); end
    checks++;
    if (cfg_busy !== 1'b1) begin errors++; $display("FAIL load_busy_set: got %b want 1", cfg_busy); end
    // Both old channels wrap on the next edge and switch to 4 and 6 there.
    for (int j = 0; j < 12; j++) begin
      step();
      e_clk = {exp_hi(j % 6, 6), exp_hi(j % 4, 4)};
      e_tc  = {(j % 6) == 0, (j % 4) == 0};
      checks++;
      if (clk_div !== e_clk) begin errors++; $display("FAIL load_clk[%0d]: got %b want %b", j, clk_div, e_clk); end
      checks++;
      if (tc !== e_tc) begin errors++; $display("FAIL load_tc[%0d]: got %b want %b", j, tc, e_tc); end
      checks++;
      if (cfg_busy !== 1'b0) begin errors++; $display("FAIL load_busy_clear[%0d]: got %b want 0", j, cfg_busy); end
    end
  endtask

  task automatic test_busy_reject();
    int c0, c1, r0, r1;
    logic [1:0] e_clk;
    logic [1:0] e_tc;
    // Channels at 4 and 6 in phase: ch0 switches to 3 at j=4, ch1 to 5 at j=6.
    for (int j = 0; j < 16; j++) begin
      cfg_load  = (j < 2);
      div_ratio = (j == 0) ? {4'd5, 4'd3} : {4'd1, 4'd1};
      step();
      cfg_load = 1'b0;
      r0 = (j < 4) ? 4 : 3;
      c0 = (j < 4) ? j : (j - 4) % 3;
      r1 = (j < 6) ? 6 : 5;
      c1 = (j < 6) ? j : (j - 6) % 5;
      e_clk = {exp_hi(c1, r1), exp_hi(c0, r0)};
      e_tc  = {c1 == 0, c0 == 0};
      checks++;
      if (clk_div !== e_clk) begin errors++; $display("FAIL stagger_clk[%0d]: got %b want %b", j, clk_div, e_clk); end
      checks++;
      if (tc !== e_tc) begin errors++; $display("FAIL stagger_tc[%0d]: got %b want %b", j, tc, e_tc); end
      checks++;
      if (cfg_busy !== (j < 6)) begin errors++; $display("FAIL stagger_busy[%0d]: got %b want %b", j, cfg_busy, j < 6); end
      checks++;
      if (cfg_err !== (j == 1)) begin errors++; $display("FAIL reject_err[%0d]: got %b want %b", j, cfg_err, j == 1); end
    end
  endtask

  task automatic test_align();
    int base;
    logic [1:0] e_clk;
    logic [1:0] e_tc;
    // Ratios 3 and 5 out of phase; align at i=0, and again at i=3 where ch0 wraps anyway.
    for (int i = 0; i < 8; i++) begin
      align = (i == 0) || (i == 3);
      step();
      align = 1'b0;
      base  = (i < 3) ? i : i - 3;
      e_clk = {exp_hi(base % 5, 5), exp_hi(base % 3, 3)};
      e_tc  = {(base % 5) == 0, (base % 3) == 0};
      checks++;
      if (tc !== e_tc) begin errors++; $display("FAIL align_tc[%0d]: got %b want %b", i, tc, e_tc); end
      if (i != 3) begin
        checks++;
        if (clk_div !== e_clk) begin errors++; $display("FAIL align_clk[%0d]: got %b want %b", i, clk_div, e_clk); end
      end
    end
  endtask

  task automatic test_odd_duty();
    int hi;
    int e_hi;
    align = 1'b1;
    step();
    align = 1'b0;
    hi = 0;
    // One steady ratio-5 period on ch1, sampled after every edge.
    for (int c = 1; c <= 5; c++) begin
      step();
      hi += int'(clk_div[1]);
      @(negedge clk_ext);
      #1;
      hi += int'(clk_div[1]);
    end
`ifdef ODD_DUTY50_EN
    e_hi = 5;
`else
    e_hi = 4;
`endif
    checks++;
    if (hi !== e_hi) begin errors++; $display("FAIL odd_duty_high_halfcycles: got %0d want %0d", hi, e_hi); end
  endtask

  task automatic test_disable();
    // Align with accepted load: ratio 1 on ch0 takes effect at once, nothing left pending.
    align     = 1'b1;
    cfg_load  = 1'b1;
    div_ratio = {4'd5, 4'd1};
    step();
    align    = 1'b0;
    cfg_load = 1'b0;
    checks++;
    if (tc !== 2'b10) begin errors++; $display("FAIL align_load_tc: got %b want 10", tc); end
    checks++;
    if (clk_div[0] !== 1'b0) begin errors++; $display("FAIL disable_clk_now: got %b want 0", clk_div[0]); end
    checks++;
    if (cfg_busy !== 1'b0) begin errors++; $display("FAIL align_load_busy: got %b want 0", cfg_busy); end
    for (int i = 1; i <= 10; i++) begin
      cfg_load  = (i == 5);
      div_ratio = {4'd5, 4'd3};
      step();
      cfg_load = 1'b0;
      if (i <= 5) begin
        checks++;
        if ({clk_div[0], tc[0]} !== 2'b00) begin
          errors++; $display("FAIL disable_hold[%0d]: got clk=%b tc=%b want 0 0", i, clk_div[0], tc[0]);
        end
      end
      if (i == 5) begin
        checks++;
        if ({cfg_busy, tc[1]} !== 2'b11) begin
          errors++; $display("FAIL reenable_load: got busy=%b tc1=%b want 1 1", cfg_busy, tc[1]);
        end
      end
      if (i == 6) begin
        checks++;
        if ({clk_div[0], tc[0]} !== {exp_hi(0, 3), 1'b1}) begin
          errors++; $display("FAIL reenable_resume: got clk=%b tc=%b want %b 1", clk_div[0], tc[0], exp_hi(0, 3));
        end
      end
      if (i == 7) begin
        checks++;
        if (tc[0] !== 1'b0) begin errors++; $display("FAIL reenable_tc_single: got %b want 0", tc[0]); end
      end
      if (i == 9) begin
        checks++;
        if (cfg_busy !== 1'b1) begin errors++; $display("FAIL reenable_busy_hold: got %b want 1", cfg_busy); end
      end
      if (i == 10) begin
        checks++;
        if ({cfg_busy, tc[1]} !== 2'b01) begin
          errors++; $display("FAIL reenable_busy_drop: got busy=%b tc1=%b want 0 1", cfg_busy, tc[1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] e;
    cfg_load  = 1'b1;
    div_ratio = {4'd6, 4'd6};
    step();
    cfg_load = 1'b0;
    checks++;
    if (cfg_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", cfg_busy); end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({cfg_busy, clk_div, tc} !== 5'b0) begin
      errors++; $display("FAIL midrst_async: got busy=%b clk=%b tc=%b want 0", cfg_busy, clk_div, tc);
    end
    @(posedge clk_ext);
    #1;
    rst_n = 1'b1;
    // Pending ratio 6 discarded: channels resume at the default ratio 2.
    for (int i = 0; i < 4; i++) begin
      step();
      e = (i % 2 == 0) ? 2'b11 : 2'b00;
      checks++;
      if (clk_div !== e) begin errors++; $display("FAIL midrst_clk[%0d]: got %b want %b", i, clk_div, e); end
      checks++;
      if (tc !== e) begin errors++; $display("FAIL midrst_tc[%0d]: got %b want %b", i, tc, e); end
      checks++;
      if (cfg_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy[%0d]: got %b want 0", i, cfg_busy); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_load();
    test_busy_reject();
    test_align();
    test_odd_duty();
    test_disable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 The block SHALL have parameter NCH, default 2, meaning the number of independent divider channels.
REQ-002 The block SHALL have parameter CW, default 4, meaning the width of each ratio field and counter.
REQ-003 The block SHALL have parameter DEF_RATIO, default 2, meaning the ratio loaded into every channel at reset.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, named clk_ext and rst_n as elsewhere in the codebase.
REQ-005 The block SHALL have these ports:
- clk_ext  in  1  source clock; all logic rises on it unless REQ-021 says otherwise.
- rst_n  in  1  asynchronous active-low reset.
- div_ratio  in  NCH*CW  packed ratios; channel k uses bits [k*CW +: CW].
- cfg_load  in  1  one-cycle strobe that captures div_ratio.
- align  in  1  one-cycle strobe that restarts all enabled channels in phase.
- clk_div  out  NCH  divided clocks.
- tc  out  NCH  one-cycle pulse per channel on each counter wrap.
- cfg_busy  out  1  high while any captured ratio is not yet applied.
- cfg_err  out  1  one-cycle pulse when a cfg_load is rejected.

Function
REQ-006 Each channel SHALL hold an active ratio R, a shadow ratio S, a pending flag P and a counter cnt running 0..R-1.
REQ-007 A channel with R >= 2 SHALL increment cnt each clk_ext rising edge and wrap to 0 after R-1.
REQ-008 On every wrap to 0, tc[k] SHALL be high for exactly that one cycle.
REQ-009 The channel output SHALL be registered; there SHALL be no combinational path from inputs to clk_div.
REQ-010 For even R, clk_div[k] SHALL be high for cnt in 0..R/2-1 and low otherwise, giving 50% duty and period R.
REQ-011 For odd R, the duty SHALL follow REQ-021 / REQ-022.
REQ-012 A channel with R < 2 SHALL be disabled:
- clk_div[k] and tc[k] held low;
- cnt held at 0.
REQ-013 cfg_load with cfg_busy low SHALL, on that edge:
- copy every div_ratio field into S;
- set P for every channel;
- make cfg_busy high from the next cycle.
REQ-014 cfg_load with cfg_busy high SHALL be ignored: S and P unchanged, and cfg_err pulses high for one cycle.
REQ-015 An enabled channel with P set SHALL apply S at its next wrap only, then clear P:
- R becomes S; cnt becomes 0;
- the new waveform starts at that rising edge with no runt pulse.
REQ-016 A disabled channel with P set SHALL apply S on the next clk_ext edge.
REQ-017 cfg_busy SHALL be the OR of all P flags, registered.
REQ-018 align SHALL force cnt to 0 on the next edge in every enabled channel:
- clk_div goes high and tc pulses on that edge;
- any P set also applies S on that same edge.
REQ-019 When align and an accepted cfg_load occur on the same edge, the new ratios SHALL take effect on that same edge, and P SHALL remain clear.
REQ-020 When a channel's wrap coincides with align, the channel SHALL produce a single restart with a single tc pulse.

Reset
REQ-023 While rst_n is low, every channel SHALL have R = S = DEF_RATIO, P = 0, cnt = DEF_RATIO-1.
REQ-024 While rst_n is low, clk_div, tc, cfg_busy and cfg_err SHALL all be 0, and every internal negedge flop SHALL also be cleared.
REQ-025 After rst_n deasserts, the first clk_ext rising edge SHALL wrap every enabled channel: clk_div goes high and tc pulses.
REQ-026 Reset asserted mid-update SHALL discard S and P.

Configuration
REQ-021 With macro ODD_DUTY50_EN defined, odd R SHALL give 50% duty:
- a rising-edge term is high for cnt 0..(R-1)/2;
- a clk_ext falling-edge retimed copy of that term is ANDed with it;
- the output is high for R/2 clk_ext cycles.
REQ-022 Without ODD_DUTY50_EN, odd R SHALL be high for cnt 0..(R-3)/2 and low for the rest of the R-cycle period, and no falling-edge logic SHALL be present.

Verification
REQ-027 Reset release with defaults: clk_div toggles every cycle (period 2), and tc pulses every 2 cycles on both channels.
REQ-028 cfg_load with ratio 4 and ratio 6, issued mid-period:
- cfg_busy goes high next cycle;
- each channel switches only at its own wrap, with no pulse shorter than 1 cycle;
- cfg_busy drops after the later switch.
REQ-029 Second cfg_load while busy: cfg_err pulses once, and the ratios from the first load remain in effect.
REQ-030 Channels running at ratios 3 and 5, then align pulsed: both clk_div rise on the same edge and both tc pulse together.
REQ-031 Ratio 5:
- with ODD_DUTY50_EN: high 2.5 cycles, low 2.5 cycles;
- without it: high 2 cycles, low 3 cycles.
REQ-032 Ratio 1 loaded: clk_div and tc are held low from the next edge; loading ratio 3 afterwards resumes the channel on the next edge.
